// File: rtl/tdp_tile_reader_if.sv
// Output beat stream of the tile reader: one data word per accepted beat,
// m_last tagging the final element of the tile.
`timescale 1ns/1ps

// Handshake: a beat transfers on a rising edge where m_valid and m_ready are
// both high; once m_valid is raised the source holds m_valid, m_data and m_last
// unchanged until that transfer, and m_ready may be driven at any time.
interface tdp_tile_reader_if #(
    parameter int DATA_W = 16
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/tdp_tile_reader.sv
// Walks a rows x cols tile of a single-port buffer in row-major order and
// streams one word per element, zeroing words whose address lies past the buffer.
`timescale 1ns/1ps

module tdp_tile_reader #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 20480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_rows,
    input  logic [7:0]        num_cols,
    input  logic [ADDR_W-1:0] row_stride,
    output logic              busy,
    output logic              done,
    output logic              oob_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    tdp_tile_reader_if.master m_if,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        rows_q, rows_d;
    logic [7:0]        cols_q, cols_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [7:0]        r_q, r_d;
    logic [7:0]        c_q, c_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              oob_q, oob_d;

    logic              load;
    logic              last_col;
    logic              last_row;
    logic              last_elem;
    logic              elem_oob;
    logic [31:0]       addr_ext;
    logic [ADDR_W-1:0] next_row_base;

    // Output register may take a new element whenever it is empty or draining.
    assign load          = (state_q == S_RUN) && (!valid_q || m_if.m_ready);
    assign last_col      = (c_q == cols_q - 8'd1);
    assign last_row      = (r_q == rows_q - 8'd1);
    assign last_elem     = last_col && last_row;
    assign addr_ext      = 32'(addr_q);
    assign elem_oob      = (addr_ext >= 32'(MEM_DEPTH));
    assign next_row_base = row_base_q + stride_q;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        stride_d   = stride_q;
        r_d        = r_q;
        c_d        = c_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        done_d     = 1'b0;
        oob_d      = oob_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d   = num_rows;
                    cols_d   = num_cols;
                    stride_d = row_stride;
                    oob_d    = 1'b0;
                    if (num_rows != 8'd0 && num_cols != 8'd0) begin
                        r_d        = 8'd0;
                        c_d        = 8'd0;
                        row_base_d = base_addr;
                        addr_d     = base_addr;
                        state_d    = S_RUN;
                    end else begin
                        // Empty tile: nothing to stream, just acknowledge.
                        done_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = elem_oob ? '0 : mem_rdata;
                    last_d  = last_elem;
                    if (elem_oob) begin
                        oob_d = 1'b1;
                    end
                    if (last_elem) begin
                        state_d = S_DRAIN;
                    end else if (last_col) begin
                        c_d        = 8'd0;
                        r_d        = r_q + 8'd1;
                        row_base_d = next_row_base;
                        addr_d     = next_row_base;
                    end else begin
                        c_d    = c_q + 8'd1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (valid_q && m_if.m_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            stride_q   <= '0;
            r_q        <= '0;
            c_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            stride_q   <= stride_d;
            r_q        <= r_d;
            c_q        <= c_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            done_q     <= done_d;
            oob_q      <= oob_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign oob_err     = oob_q;
    assign mem_addr    = (state_q == S_RUN) ? addr_q : '0;
    assign mem_we      = 1'b0;
    assign m_if.m_valid = valid_q;
    assign m_if.m_data  = data_q;
    assign m_if.m_last  = last_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_tdp_tile_reader.sv
// Directed bench for tdp_tile_reader: a combinational buffer model answers
// mem_addr, and each scenario task checks the beat stream cycle by cycle.
`timescale 1ns/1ps

module tb_tdp_tile_reader;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 20480;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [7:0]        num_rows = '0;
    logic [7:0]        num_cols = '0;
    logic [ADDR_W-1:0] row_stride = '0;
    logic              busy;
    logic              done;
    logic              oob_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_state;

    int vectors = 0;
    int miscompares = 0;

    tdp_tile_reader_if #(.DATA_W(DATA_W)) m_if ();

    tdp_tile_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .num_cols(num_cols), .row_stride(row_stride),
        .busy(busy), .done(done), .oob_err(oob_err), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .m_if(m_if), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {1'b0, a} ^ 16'hC3A5;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    // Drives a one-cycle start; returns at the falling edge after it was sampled.
    task automatic start_tile(input logic [ADDR_W-1:0] b, input logic [7:0] r,
                              input logic [7:0] c, input logic [ADDR_W-1:0] s);
        @(negedge clk);
        base_addr = b; num_rows = r; num_cols = c; row_stride = s; start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        base_addr  = ADDR_W'($urandom_range(0, 32767));
        num_rows   = 8'($urandom_range(1, 255));
        num_cols   = 8'($urandom_range(1, 255));
        row_stride = ADDR_W'($urandom_range(0, 32767));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_if.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (m_if.m_valid !== 1'b0 || m_if.m_last !== 1'b0) begin miscompares++; $display("FAIL reset_valid_last got=%b%b want=00", m_if.m_valid, m_if.m_last); end
        vectors++; if (m_if.m_data !== 16'h0) begin miscompares++; $display("FAIL reset_data got=%h want=0000", m_if.m_data); end
        vectors++; if ({busy, done, oob_err, mem_we} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got=%b want=0000", {busy, done, oob_err, mem_we}); end
        vectors++; if (mem_addr !== 15'h0 || dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_addr_state got=%h/%0d want=0000/0", mem_addr, dbg_state); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || m_if.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_release got=%b%b%b want=000", busy, done, m_if.m_valid); end
    endtask

    task automatic test_basic();
        logic [ADDR_W-1:0] exp_a [6];
        exp_a = '{15'h100, 15'h101, 15'h102, 15'h110, 15'h111, 15'h112};
        m_if.m_ready = 1'b1;
        start_tile(15'h0100, 8'd2, 8'd3, 15'd16);
        vectors++; if (busy !== 1'b1 || m_if.m_valid !== 1'b0) begin miscompares++; $display("FAIL basic_first busy/valid got=%b%b want=10", busy, m_if.m_valid); end
        vectors++; if (mem_addr !== exp_a[0]) begin miscompares++; $display("FAIL basic_addr0 got=%h want=%h", mem_addr, exp_a[0]); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++; if (m_if.m_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid k=%0d got=%b want=1", k, m_if.m_valid); end
            vectors++; if (m_if.m_data !== mem_word(exp_a[k])) begin miscompares++; $display("FAIL basic_data k=%0d got=%h want=%h", k, m_if.m_data, mem_word(exp_a[k])); end
            vectors++; if (m_if.m_last !== (k == 5)) begin miscompares++; $display("FAIL basic_last k=%0d got=%b want=%b", k, m_if.m_last, (k == 5)); end
            vectors++; if (mem_addr !== ((k < 5) ? exp_a[k+1] : 15'h0)) begin miscompares++; $display("FAIL basic_addr k=%0d got=%h want=%h", k, mem_addr, (k < 5) ? exp_a[k+1] : 15'h0); end
            vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_early_done k=%0d got=%b want=0", k, done); end
        end
        @(negedge clk);
        vectors++; if ({done, busy, m_if.m_valid} !== 3'b100) begin miscompares++; $display("FAIL basic_done got=%b want=100", {done, busy, m_if.m_valid}); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got=%b want=0", done); end
    endtask

    // Stalled stream; also pulses start mid-tile, which must be ignored.
    task automatic test_stall();
        logic [ADDR_W-1:0] exp_a [6];
        logic              pat [4];
        logic [DATA_W-1:0] held_d;
        logic              held_l;
        logic              prev_stall;
        int                idx;
        int                cyc;
        bit                finished;
        exp_a = '{15'h100, 15'h101, 15'h102, 15'h110, 15'h111, 15'h112};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        idx = 0; cyc = 0; prev_stall = 1'b0; finished = 0;
        held_d = '0; held_l = 1'b0;
        start_tile(15'h0100, 8'd2, 8'd3, 15'd16);
        while (!finished && cyc < 60) begin
            m_if.m_ready = pat[cyc % 4];
            start = (cyc == 3);
            base_addr = 15'h0555;
            cyc++;
            if (m_if.m_valid) begin
                if (prev_stall) begin
                    vectors++; if (m_if.m_data !== held_d || m_if.m_last !== held_l) begin miscompares++; $display("FAIL stall_hold cyc=%0d got=%h/%b want=%h/%b", cyc, m_if.m_data, m_if.m_last, held_d, held_l); end
                end
                if (m_if.m_ready) begin
                    vectors++; if (idx > 5 || m_if.m_data !== mem_word(exp_a[idx % 6])) begin miscompares++; $display("FAIL stall_data idx=%0d got=%h want=%h", idx, m_if.m_data, mem_word(exp_a[idx % 6])); end
                    vectors++; if (m_if.m_last !== (idx == 5)) begin miscompares++; $display("FAIL stall_last idx=%0d got=%b want=%b", idx, m_if.m_last, (idx == 5)); end
                    if (m_if.m_last) finished = 1;
                    idx++;
                end
                prev_stall = !m_if.m_ready;
                held_d = m_if.m_data;
                held_l = m_if.m_last;
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        m_if.m_ready = 1'b1;
        vectors++; if (!finished || idx != 6) begin miscompares++; $display("FAIL stall_count got=%0d beats want=6 (finished=%0d)", idx, finished); end
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL stall_done got=%b%b want=10", done, busy); end
        @(negedge clk);
    endtask

    task automatic test_zero_dim();
        logic [7:0] rr [2];
        logic [7:0] cc [2];
        rr = '{8'd0, 8'd3};
        cc = '{8'd5, 8'd0};
        for (int i = 0; i < 2; i++) begin
            start_tile(15'h0010, rr[i], cc[i], 15'd1);
            vectors++; if ({busy, done, m_if.m_valid} !== 3'b010) begin miscompares++; $display("FAIL zero_pulse case=%0d got=%b want=010", i, {busy, done, m_if.m_valid}); end
            @(negedge clk);
            vectors++; if ({busy, done, m_if.m_valid} !== 3'b000) begin miscompares++; $display("FAIL zero_after case=%0d got=%b want=000", i, {busy, done, m_if.m_valid}); end
        end
    endtask

    task automatic test_oob();
        logic [DATA_W-1:0] exp_d [4];
        exp_d = '{mem_word(15'h4FFE), mem_word(15'h4FFF), 16'h0, 16'h0};
        m_if.m_ready = 1'b1;
        start_tile(15'h4FFE, 8'd1, 8'd4, 15'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== exp_d[k]) begin miscompares++; $display("FAIL oob_data k=%0d got=%b/%h want=1/%h", k, m_if.m_valid, m_if.m_data, exp_d[k]); end
            vectors++; if (oob_err !== (k >= 2)) begin miscompares++; $display("FAIL oob_flag k=%0d got=%b want=%b", k, oob_err, (k >= 2)); end
            vectors++; if (m_if.m_last !== (k == 3)) begin miscompares++; $display("FAIL oob_last k=%0d got=%b want=%b", k, m_if.m_last, (k == 3)); end
        end
        @(negedge clk);
        vectors++; if (done !== 1'b1 || oob_err !== 1'b1) begin miscompares++; $display("FAIL oob_done got=%b%b want=11", done, oob_err); end
        repeat (2) @(negedge clk);
        vectors++; if (oob_err !== 1'b1) begin miscompares++; $display("FAIL oob_sticky got=%b want=1", oob_err); end
    endtask

    task automatic test_wrap();
        m_if.m_ready = 1'b1;
        start_tile(15'h7FFF, 8'd1, 8'd2, 15'd5);
        vectors++; if (oob_err !== 1'b0 || mem_addr !== 15'h7FFF) begin miscompares++; $display("FAIL wrap_start got=%b/%h want=0/7fff", oob_err, mem_addr); end
        @(negedge clk);
        vectors++; if (m_if.m_data !== 16'h0 || oob_err !== 1'b1) begin miscompares++; $display("FAIL wrap_beat0 got=%h/%b want=0000/1", m_if.m_data, oob_err); end
        vectors++; if (mem_addr !== 15'h0000 || m_if.m_last !== 1'b0) begin miscompares++; $display("FAIL wrap_addr1 got=%h/%b want=0000/0", mem_addr, m_if.m_last); end
        @(negedge clk);
        vectors++; if (m_if.m_data !== mem_word(15'h0) || m_if.m_last !== 1'b1) begin miscompares++; $display("FAIL wrap_beat1 got=%h/%b want=%h/1", m_if.m_data, m_if.m_last, mem_word(15'h0)); end
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got=%b want=1", done); end
    endtask

    task automatic test_single();
        m_if.m_ready = 1'b1;
        start_tile(15'h0042, 8'd1, 8'd1, 15'd0);
        vectors++; if (oob_err !== 1'b0) begin miscompares++; $display("FAIL single_oob_clear got=%b want=0", oob_err); end
        @(negedge clk);
        vectors++; if ({m_if.m_valid, m_if.m_last} !== 2'b11 || m_if.m_data !== mem_word(15'h0042)) begin miscompares++; $display("FAIL single_beat got=%b%b/%h want=11/%h", m_if.m_valid, m_if.m_last, m_if.m_data, mem_word(15'h0042)); end
        @(negedge clk);
        vectors++; if ({done, m_if.m_valid, busy} !== 3'b100) begin miscompares++; $display("FAIL single_done got=%b want=100", {done, m_if.m_valid, busy}); end
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] exp_a [4];
        exp_a = '{15'h300, 15'h301, 15'h304, 15'h305};
        m_if.m_ready = 1'b1;
        start_tile(15'h0200, 8'd4, 8'd4, 15'h20);
        repeat (3) @(negedge clk);
        vectors++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== mem_word(15'h0202)) begin miscompares++; $display("FAIL rmid_beat3 got=%b/%h want=1/%h", m_if.m_valid, m_if.m_data, mem_word(15'h0202)); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if ({m_if.m_valid, m_if.m_last, busy, done} !== 4'b0000 || m_if.m_data !== 16'h0) begin miscompares++; $display("FAIL rmid_async got=%b/%h want=0000/0000", {m_if.m_valid, m_if.m_last, busy, done}, m_if.m_data); end
        vectors++; if (mem_addr !== 15'h0 || dbg_state !== 2'd0) begin miscompares++; $display("FAIL rmid_addr got=%h/%0d want=0000/0", mem_addr, dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (done !== 1'b0 || m_if.m_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_no_done i=%0d got=%b%b want=00", i, done, m_if.m_valid); end
        end
        start_tile(15'h0300, 8'd2, 8'd2, 15'd4);
        vectors++; if (mem_addr !== exp_a[0] || m_if.m_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_new_addr0 got=%h/%b want=%h/0", mem_addr, m_if.m_valid, exp_a[0]); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== mem_word(exp_a[k]) || m_if.m_last !== (k == 3)) begin miscompares++; $display("FAIL rmid_new k=%0d got=%b/%h/%b want=1/%h/%b", k, m_if.m_valid, m_if.m_data, m_if.m_last, mem_word(exp_a[k]), (k == 3)); end
        end
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rmid_new_done got=%b want=1", done); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_if.m_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_zero_dim();
        test_oob();
        test_wrap();
        test_single();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
